// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the register file read sequencer.
// Imported by the sequencer top and its return buffer.
package reg_file_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } out_word_t;

endpackage

// File: rtl/reg_file_rd_fifo.sv
// Two-entry first-word-fall-through buffer of {addr, data}.
// An incoming word is visible at the head in its arrival cycle when empty.
module reg_file_rd_fifo
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [1:0]        occupancy
);

    out_word_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;
    logic       bypass;
    logic       store;
    logic       drop;

    assign full      = (occ == 2'd2);
    assign empty     = (occ == 2'd0);
    assign occupancy = occ;

    // Head selection and decision whether a word is stored or passed through
    always_comb begin
        {head_addr, head_data} = '0;
        bypass = (occ == 2'd0);
        store  = push && !(bypass && pop);
        drop   = pop && !bypass;
        if (!bypass) begin
            {head_addr, head_data} = mem[rd_ptr];
        end else if (push) begin
            {head_addr, head_data} = {push_addr, push_data};
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= {push_addr, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (drop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + 2'(store) - 2'(drop);
        end
    end

endmodule

// File: rtl/reg_file_reader.sv
// Walks a wrapping address range through the register file read port
// and streams each word, tagged with its address, on a valid/ready port.
module reg_file_reader
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_ptr;
    logic [ADDR_W-1:0] ret_addr;
    logic [CNT_W-1:0]  issue_left;
    logic [CNT_W-1:0]  ret_left;
    logic [CNT_W-1:0]  cnt_sat;
    logic              ret_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_occ;
    logic [2:0]        occ_next;
    logic              pop;
    logic              credit_ok;
    logic              accept;
    logic              zero_cmd;
    logic              issue;
    logic              last_pop;
    logic              rd_en_next;
    logic [ADDR_W-1:0] rd_addr_next;
    logic              busy_next;
    logic              done_next;

    reg_file_rd_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ret_valid),
        .push_addr (ret_addr),
        .push_data (rd_data),
        .pop       (pop),
        .head_addr (out_addr),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    assign out_valid = !fifo_empty || ret_valid;
    assign pop       = out_valid && out_ready;

    // A read may issue only if its word is sure to find a free slot
    always_comb begin
        cnt_sat   = (count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : count;
        occ_next  = 3'(fifo_occ) + 3'(ret_valid) - 3'(pop);
        credit_ok = (occ_next + 3'(rd_en)) < 3'd2;
        accept    = (state == IDLE) && start && !done && (cnt_sat != '0);
        zero_cmd  = (state == IDLE) && start && !done && (cnt_sat == '0);
        issue     = (state == ISSUE) && (issue_left != '0)
                    && credit_ok && !fifo_full;
        last_pop  = (state == DRAIN) && pop && (ret_left == CNT_W'(1));
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cnt_sat == CNT_W'(1)) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue && (issue_left == CNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        rd_en_next   = accept || issue;
        rd_addr_next = accept ? start_addr : addr_ptr;
        busy_next    = busy;
        if (accept) begin
            busy_next = 1'b1;
        end
        if (last_pop) begin
            busy_next = 1'b0;
        end
        done_next = zero_cmd || last_pop;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs, counters and the one-cycle address delay for returning data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_ptr   <= '0;
            issue_left <= '0;
            ret_left   <= '0;
            ret_valid  <= 1'b0;
            ret_addr   <= '0;
        end else begin
            rd_en <= rd_en_next;
            busy  <= busy_next;
            done  <= done_next;
            if (rd_en_next) begin
                rd_addr <= rd_addr_next;
            end
            if (accept) begin
                addr_ptr   <= start_addr + ADDR_W'(1);
                issue_left <= cnt_sat - CNT_W'(1);
            end else if (issue) begin
                addr_ptr   <= addr_ptr + ADDR_W'(1);
                issue_left <= issue_left - CNT_W'(1);
            end
            if (accept) begin
                ret_left <= cnt_sat;
            end else if (pop && (ret_left != '0)) begin
                ret_left <= ret_left - CNT_W'(1);
            end
            ret_valid <= rd_en;
            if (rd_en) begin
                ret_addr <= rd_addr;
            end
        end
    end

endmodule
